// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared states and constants for the instruction-fetch responder
package fetch_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } fetch_state_e;

endpackage

// File: rtl/byte_mem.sv
// rtl/byte_mem.sv - byte array with one program-load write port and a 4-byte little-endian read
module byte_mem
  import fetch_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_word
);

  logic [BYTE_W-1:0] mem [MEM_BYTES];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Combinational read: a write on the sampling edge is not yet visible.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < WORD_W / BYTE_W; i++) begin
      rd_word[i*BYTE_W +: BYTE_W] = mem[rd_addr + ADDR_W'(i)];
    end
  end

endmodule

// File: rtl/instr_mem_responder.sv
// rtl/instr_mem_responder.sv - multi-cycle instruction memory behind a FETCH/BUSYWAIT/VALID handshake
module instr_mem_responder
  import fetch_pkg::*;
#(
  parameter int MEM_BYTES    = 1024,
  parameter int READ_LATENCY = 4,
  parameter int ADDR_W       = 10
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FETCH,
  input  logic [31:0]       PC,
  output logic [31:0]       INSTRUCTION,
  output logic              VALID,
  output logic              BUSYWAIT,
  output logic              ERROR,
  input  logic              PROG_EN,
  input  logic [ADDR_W-1:0] PROG_ADDR,
  input  logic [7:0]        PROG_DATA
);

  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  fetch_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              error_q, error_d;
  logic [WORD_W-1:0] mem_word;
  logic              bad_pc;

  byte_mem #(
    .MEM_BYTES(MEM_BYTES),
    .ADDR_W   (ADDR_W)
  ) u_mem (
    .clk    (CLK),
    .wr_en  (PROG_EN & ~RESET),
    .wr_addr(PROG_ADDR),
    .wr_data(PROG_DATA),
    .rd_addr(addr_q),
    .rd_word(mem_word)
  );

  // Full 32-bit compare so high addresses never alias into the array.
  assign bad_pc = (PC[1:0] != 2'b00) || (PC > LAST_WORD);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    valid_d = valid_q;
    error_d = error_q;
    unique case (state_q)
      IDLE: begin
        if (FETCH) begin
          addr_d = PC[ADDR_W-1:0];
          if (bad_pc) begin
            instr_d = NOP_WORD;
            valid_d = 1'b1;
            error_d = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = CNT_W'(READ_LATENCY - 1);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (!FETCH) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          instr_d = mem_word;
          valid_d = 1'b1;
          error_d = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        valid_d = 1'b0;
        error_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  assign INSTRUCTION = instr_q;
  assign VALID       = valid_q;
  assign ERROR       = error_q;
  assign BUSYWAIT    = FETCH & (state_q != RESP);

endmodule

// File: tb/tb_instr_mem_responder.sv
// tb/tb_instr_mem_responder.sv - randomized and directed bench against a timestamp-based fetch model
module tb_instr_mem_responder;

  localparam int MB = 1024;
  localparam int RL = 4;
  localparam int AW = 10;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          FETCH = 1'b0;
  logic [31:0]   PC = '0;
  logic [31:0]   INSTRUCTION;
  logic          VALID, BUSYWAIT, ERROR;
  logic          PROG_EN = 1'b0;
  logic [AW-1:0] PROG_ADDR = '0;
  logic [7:0]    PROG_DATA = '0;

  int tests = 0;
  int fails = 0;

  instr_mem_responder #(
    .MEM_BYTES(MB),
    .READ_LATENCY(RL),
    .ADDR_W(AW)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .FETCH(FETCH),
    .PC(PC),
    .INSTRUCTION(INSTRUCTION),
    .VALID(VALID),
    .BUSYWAIT(BUSYWAIT),
    .ERROR(ERROR),
    .PROG_EN(PROG_EN),
    .PROG_ADDR(PROG_ADDR),
    .PROG_DATA(PROG_DATA)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: edge timestamps, a byte array, and the handshake rules.
  logic [7:0]  ref_mem [MB];
  logic [31:0] exp_instr = '0;
  logic        exp_valid = 1'b0;
  logic        exp_error = 1'b0;
  bit          chk_en = 1'b0;
  bit          req_active = 1'b0;
  int unsigned edge_n = 0;
  int unsigned req_edge = 0;
  int unsigned earliest = 0;
  int unsigned req_pc = 0;

  function automatic logic [31:0] ref_word(input int unsigned a);
    return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
  endfunction

  function automatic bit pc_is_bad(input logic [31:0] p);
    return (p % 4 != 0) || (p > 32'(MB - 4));
  endfunction

  initial begin
    forever begin
      @(posedge CLK);
      edge_n++;
      if (RESET) begin
        chk_en     = 1'b1;
        req_active = 1'b0;
        exp_valid  = 1'b0;
        exp_error  = 1'b0;
        exp_instr  = '0;
        earliest   = edge_n + 1;
      end else begin
        exp_valid = 1'b0;
        exp_error = 1'b0;
        if (req_active && !FETCH) begin
          req_active = 1'b0;
        end else if (req_active && edge_n == req_edge + RL) begin
          exp_instr  = ref_word(req_pc);
          exp_valid  = 1'b1;
          req_active = 1'b0;
          earliest   = edge_n + 2;
        end else if (!req_active && FETCH && edge_n >= earliest) begin
          if (pc_is_bad(PC)) begin
            exp_instr = '0;
            exp_valid = 1'b1;
            exp_error = 1'b1;
            earliest  = edge_n + 2;
          end else begin
            req_active = 1'b1;
            req_edge   = edge_n;
            req_pc     = PC;
          end
        end
        if (PROG_EN) ref_mem[PROG_ADDR] = PROG_DATA;
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (chk_en) begin
        check("valid", 32'(VALID), 32'(exp_valid));
        check("error", 32'(ERROR), 32'(exp_error));
        check("busywait", 32'(BUSYWAIT), 32'(FETCH && !exp_valid));
        check("instruction", INSTRUCTION, exp_instr);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic prog(input int unsigned a, input logic [7:0] d);
    PROG_EN = 1'b1;
    PROG_ADDR = AW'(a);
    PROG_DATA = d;
    tick();
    PROG_EN = 1'b0;
  endtask

  task automatic wait_valid(output logic [31:0] w, output logic e, output logic bw, output int n);
    w = '0; e = 1'b0; bw = 1'b0; n = 0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge CLK);
      if (VALID === 1'b1) begin
        w = INSTRUCTION; e = ERROR; bw = BUSYWAIT; n = i;
        return;
      end
    end
    tests++;
    fails++;
    $display("FAIL wait_valid: no VALID within 64 cycles, got none, expected a pulse");
  endtask

  task automatic fetch_once(input logic [31:0] p, output logic [31:0] w, output logic e, output int n);
    logic bw;
    FETCH = 1'b1;
    PC = p;
    wait_valid(w, e, bw, n);
    tick();
    FETCH = 1'b0;
    tick();
  endtask

  function automatic logic [31:0] rand_pc();
    case ($urandom_range(0, 9))
      0: return $urandom;
      1: return 32'(MB + 4 * $urandom_range(0, 3));
      2: return 32'(MB - 4);
      3: return 32'($urandom_range(0, 63));
      default: return 32'(4 * $urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    logic [31:0] w;
    logic e, bw;
    int n, v0, saw;

    repeat (3) tick();
    RESET = 1'b0;
    @(negedge CLK);
    check("rst_valid", 32'(VALID), 32'd0);
    check("rst_error", 32'(ERROR), 32'd0);
    check("rst_instr", INSTRUCTION, 32'h0);
    tick();

    for (int a = 0; a < MB; a++) prog(a, 8'($urandom));
    prog(0, 8'h05); prog(1, 8'h00); prog(2, 8'h04); prog(3, 8'h00);
    prog(4, 8'h09); prog(5, 8'h00); prog(6, 8'h02); prog(7, 8'h00);
    prog(8, 8'h02); prog(9, 8'h04); prog(10, 8'h06); prog(11, 8'h02);

    // First fetch straight out of reset, then back-to-back at 4 and 8.
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    FETCH = 1'b1;
    PC = 32'd0;
    #1;
    check("busy_immediate", 32'(BUSYWAIT), 32'd1);
    wait_valid(w, e, bw, n);
    check("lat_pc0", 32'(n), 32'(RL + 2));
    check("word_pc0", w, 32'h0004_0005);
    check("err_pc0", 32'(e), 32'd0);
    check("bw_in_valid", 32'(bw), 32'd0);
    v0 = int'(edge_n);
    tick();
    PC = 32'd4;
    wait_valid(w, e, bw, n);
    check("b2b_gap1", 32'(int'(edge_n) - v0), 32'(RL + 2));
    check("word_pc4", w, 32'h0002_0009);
    v0 = int'(edge_n);
    tick();
    PC = 32'd8;
    wait_valid(w, e, bw, n);
    check("b2b_gap2", 32'(int'(edge_n) - v0), 32'(RL + 2));
    check("word_pc8", w, 32'h0206_0402);
    tick();
    FETCH = 1'b0;
    tick();

    fetch_once(32'd2, w, e, n);
    check("mis_lat", 32'(n), 32'd2);
    check("mis_err", 32'(e), 32'd1);
    check("mis_word", w, 32'h0);
    fetch_once(32'd1024, w, e, n);
    check("oor_lat", 32'(n), 32'd2);
    check("oor_err", 32'(e), 32'd1);
    check("oor_word", w, 32'h0);

    FETCH = 1'b1;
    PC = 32'd4;
    tick();
    tick();
    PC = 32'd8;
    wait_valid(w, e, bw, n);
    check("pc_change_word", w, 32'h0002_0009);
    tick();
    FETCH = 1'b0;
    tick();

    FETCH = 1'b1;
    PC = 32'd8;
    tick();
    tick();
    FETCH = 1'b0;
    saw = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (VALID === 1'b1) saw++;
    end
    check("abort_no_valid", 32'(saw), 32'd0);
    check("abort_bw", 32'(BUSYWAIT), 32'd0);
    tick();

    FETCH = 1'b1;
    PC = 32'd0;
    tick();
    tick();
    RESET = 1'b1;
    FETCH = 1'b0;
    tick();
    RESET = 1'b0;
    @(negedge CLK);
    check("midrst_valid", 32'(VALID), 32'd0);
    check("midrst_instr", INSTRUCTION, 32'h0);
    check("midrst_bw", 32'(BUSYWAIT), 32'd0);
    tick();
    fetch_once(32'd0, w, e, n);
    check("retained_word", w, 32'h0004_0005);

    // Write byte 4 on the very edge that captures the word at 4.
    FETCH = 1'b1;
    PC = 32'd4;
    repeat (4) tick();
    PROG_EN = 1'b1;
    PROG_ADDR = AW'(4);
    PROG_DATA = 8'hA5;
    tick();
    PROG_EN = 1'b0;
    @(negedge CLK);
    check("same_edge_valid", 32'(VALID), 32'd1);
    check("same_edge_old", INSTRUCTION, 32'h0002_0009);
    tick();
    FETCH = 1'b0;
    tick();
    fetch_once(32'd4, w, e, n);
    check("refetch_new", w, 32'h0002_00A5);

    for (int i = 0; i < 3000; i++) begin
      PROG_EN = ($urandom_range(0, 3) == 0);
      PROG_ADDR = AW'($urandom_range(0, 63));
      PROG_DATA = 8'($urandom);
      RESET = ($urandom_range(0, 299) == 0);
      if (!FETCH) begin
        if ($urandom_range(0, 1) == 1) begin
          FETCH = 1'b1;
          PC = rand_pc();
        end
      end else if (exp_valid) begin
        if ($urandom_range(0, 1) == 1) FETCH = 1'b0;
        else PC = rand_pc();
      end else begin
        if ($urandom_range(0, 15) == 0) FETCH = 1'b0;
        else if ($urandom_range(0, 3) == 0) PC = rand_pc();
      end
      tick();
    end
    RESET = 1'b0;
    PROG_EN = 1'b0;
    FETCH = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
